// File: rtl/press_classifier.sv
// Press classifier: turns debounced presses into
// single / double / long one-cycle event pulses.
module press_classifier #(
  parameter int LONG_TICKS = 8,
  parameter int GAP_TICKS  = 2,
  parameter int CNT_W      = 4
) (
  input  logic       CLK,
  input  logic       aclr_i,
  input  logic       PRESS,
  input  logic       LEVEL,
  output logic       SINGLE,
  output logic       DOUBLE,
  output logic       LONG,
  output logic       BUSY,
  output logic [7:0] EVT_CNT
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HELD1 = 3'd1,
    WAIT2 = 3'd2,
    HELD2 = 3'd3,
    LHOLD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_TICKS - 1);

  // Tick counter must be able to hold the largest terminal count.
  if (LONG_TICKS < 2 || GAP_TICKS < 2 ||
      LONG_TICKS > (2 ** CNT_W) ||
      GAP_TICKS > (2 ** CNT_W)) begin : g_bad_params
    $error("press_classifier: tick parameters do not fit CNT_W");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             busy_q, busy_d;
  logic [7:0]       evt_q, evt_d;
  logic             evt_any;

  // Next-state, tick counter and event pulse decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (PRESS) begin
          state_d = HELD1;
          cnt_d   = '0;
        end
      end
      HELD1: begin
        if (!LEVEL) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LHOLD;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT2: begin
        if (PRESS) begin
          state_d  = HELD2;
          double_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD2: begin
        if (!LEVEL) state_d = IDLE;
      end
      LHOLD: begin
        if (!LEVEL) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    evt_any = single_d | double_d | long_d;
    evt_d   = evt_q + {7'd0, evt_any};
    busy_d  = (state_d != IDLE);
  end

  // State, counter and registered outputs; async clear wins.
  always_ff @(posedge CLK or posedge aclr_i) begin
    if (aclr_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
      evt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
      evt_q    <= evt_d;
    end
  end

  assign SINGLE  = single_q;
  assign DOUBLE  = double_q;
  assign LONG    = long_q;
  assign BUSY    = busy_q;
  assign EVT_CNT = evt_q;

endmodule
